// File: rtl/dcache_snoop_responder_if.sv
// Coherence-controller <-> dcache snoop channel.
//   ccwait      : snoop request from the controller
//   ccinv       : invalidate request from the controller
//   ccsnoopaddr : snooped word address
//   dwait       : low means the word currently on daddr/dstore was accepted
//   cctrans     : this cache holds the line in M and will supply it
//   daddr       : address of the word being supplied
//   dstore      : data of the word being supplied
// master = coherence controller side, slave = dcache snoop responder side.
interface dcache_snoop_responder_if;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dwait;
  logic        cctrans;
  logic [31:0] daddr;
  logic [31:0] dstore;

  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait,
    input  cctrans, daddr, dstore
  );

  modport slave (
    input  ccwait, ccinv, ccsnoopaddr, dwait,
    output cctrans, daddr, dstore
  );
endinterface

// File: rtl/dcache_snoop_responder.sv
// Snooped-cache end of the MSI bus protocol, one per L1 dcache.
// Answers controller snoops: reports an M hit on cctrans, forwards the
// two-word block over daddr/dstore, then downgrades the line M->S. Also
// invalidates a line on ccinv. While active it stalls the core-side FSM.
// Ports:
//   CLK, nRST   : clock, asynchronous active-low reset
//   ccif        : coherence channel (slave modport)
//   snoop_busy  : core-side FSM must hold off the arrays
//   arr_idx     : set index to the tag/data arrays (combinational read)
//   arr_valid/arr_dirty/arr_tag/arr_word0/arr_word1 : per-way array read data
//   upd_en/upd_way/upd_valid/upd_dirty : one-cycle line state write
module dcache_snoop_responder #(
  parameter  int WAYS = 2,
  parameter  int SETS = 8,
  localparam int IDXW = $clog2(SETS),
  localparam int TAGW = 32 - 3 - IDXW,
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  dcache_snoop_responder_if.slave ccif,
  output logic                   snoop_busy,
  output logic [IDXW-1:0]        arr_idx,
  input  logic [WAYS-1:0]        arr_valid,
  input  logic [WAYS-1:0]        arr_dirty,
  input  logic [WAYS*TAGW-1:0]   arr_tag,
  input  logic [WAYS*32-1:0]     arr_word0,
  input  logic [WAYS*32-1:0]     arr_word1,
  output logic                   upd_en,
  output logic [WAYW-1:0]        upd_way,
  output logic                   upd_valid,
  output logic                   upd_dirty
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, SUP0, GAP, SUP1, DOWN, INVAL
  } state_t;

  state_t state, next;

  logic [TAGW-1:0] snoop_tag, tag_q;
  logic [IDXW-1:0] snoop_idx, idx_q;
  logic [WAYW-1:0] way_c, way_q;
  logic            hit_c, dirty_c, hit_q, m_q;
  logic [31:0]     hit_word0, hit_word1;
  logic            unused_addr_bits;

  assign snoop_tag        = ccif.ccsnoopaddr[31:3+IDXW];
  assign snoop_idx        = ccif.ccsnoopaddr[2+IDXW:3];
  assign unused_addr_bits = ^ccif.ccsnoopaddr[2:0];

  // Tag compare on the set currently presented by the arrays (the snooped
  // set while IDLE). Scanning downwards lets the lowest matching way win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hit_c   = 1'b0;
    dirty_c = 1'b0;
    way_c   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (arr_valid[w] && (arr_tag[w*TAGW +: TAGW] == snoop_tag)) begin
        hit_c   = 1'b1;
        dirty_c = arr_dirty[w];
        way_c   = WAYW'(w);
      end
    end
  end

  // Block words of the latched hit way; arr_idx holds the latched set.
  always_comb begin
    hit_word0 = '0;
    hit_word1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (WAYW'(w) == way_q) begin
        hit_word0 = arr_word0[w*32 +: 32];
        hit_word1 = arr_word1[w*32 +: 32];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      tag_q <= '0;
      idx_q <= '0;
      way_q <= '0;
      hit_q <= 1'b0;
      m_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= next;
      if (state == IDLE && (ccif.ccwait || ccif.ccinv)) begin
        tag_q <= snoop_tag;
        idx_q <= snoop_idx;
        way_q <= way_c;
        hit_q <= hit_c;
        m_q   <= hit_c & dirty_c;
      end
    end
  end

  always_comb begin
    next         = state;
    ccif.cctrans = 1'b0;
    ccif.daddr   = '0;
    ccif.dstore  = '0;
    upd_en       = 1'b0;
    upd_way      = '0;
    upd_valid    = 1'b0;
    upd_dirty    = 1'b0;
    snoop_busy   = (state != IDLE);
    // While IDLE the arrays follow the snooped address so the tag compare
    // is ready on the request cycle; held at zero during reset so every
    // output reads 0.
    arr_idx      = (state == IDLE) ? (nRST ? snoop_idx : '0) : idx_q;

    unique case (state)
      IDLE: begin
        if (ccif.ccwait)     next = LOOKUP;
        else if (ccif.ccinv) next = INVAL;
      end
      LOOKUP: begin
        ccif.cctrans = m_q;
        if (m_q)               next = SUP0;
        else if (!ccif.ccwait) next = IDLE;
      end
      SUP0, GAP: begin
        ccif.cctrans = 1'b1;
        ccif.daddr   = {tag_q, idx_q, 1'b0, 2'b00};
        ccif.dstore  = hit_word0;
        if (!ccif.ccwait)                     next = IDLE;
        else if (state == GAP)                next = SUP1;
        else if (!ccif.dwait)                 next = GAP;
      end
      SUP1: begin
        ccif.cctrans = 1'b1;
        ccif.daddr   = {tag_q, idx_q, 1'b1, 2'b00};
        ccif.dstore  = hit_word1;
        if (!ccif.ccwait)     next = IDLE;
        else if (!ccif.dwait) next = DOWN;
      end
      DOWN: begin
        upd_en    = 1'b1;
        upd_way   = way_q;
        upd_valid = 1'b1;
        next      = IDLE;
      end
      INVAL: begin
        upd_en  = hit_q;
        upd_way = hit_q ? way_q : '0;
        next    = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Self-checking bench for dcache_snoop_responder: a small array model that
// applies the responder's upd_* writes, directed snoop/invalidate sequences,
// and a scoreboard of expected forwarded words and line-state writes.
module tb_dcache_snoop_responder;
  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int IDXW = 3;
  localparam int TAGW = 32 - 3 - IDXW;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  dcache_snoop_responder_if ccif ();

  logic                 snoop_busy;
  logic [IDXW-1:0]      arr_idx;
  logic [WAYS-1:0]      arr_valid, arr_dirty;
  logic [WAYS*TAGW-1:0] arr_tag;
  logic [WAYS*32-1:0]   arr_word0, arr_word1;
  logic                 upd_en, upd_valid, upd_dirty;
  logic [0:0]           upd_way;

  dcache_snoop_responder #(.WAYS(WAYS), .SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .ccif(ccif.slave),
    .snoop_busy(snoop_busy), .arr_idx(arr_idx),
    .arr_valid(arr_valid), .arr_dirty(arr_dirty), .arr_tag(arr_tag),
    .arr_word0(arr_word0), .arr_word1(arr_word1),
    .upd_en(upd_en), .upd_way(upd_way),
    .upd_valid(upd_valid), .upd_dirty(upd_dirty)
  );

  // Array model
  logic            m_valid [SETS][WAYS];
  logic            m_dirty [SETS][WAYS];
  logic [TAGW-1:0] m_tag   [SETS][WAYS];
  logic [31:0]     m_w0    [SETS][WAYS];
  logic [31:0]     m_w1    [SETS][WAYS];

  always_comb begin
    arr_valid = '0;
    arr_dirty = '0;
    arr_tag   = '0;
    arr_word0 = '0;
    arr_word1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      arr_valid[w]            = m_valid[arr_idx][w];
      arr_dirty[w]            = m_dirty[arr_idx][w];
      arr_tag[w*TAGW +: TAGW] = m_tag[arr_idx][w];
      arr_word0[w*32 +: 32]   = m_w0[arr_idx][w];
      arr_word1[w*32 +: 32]   = m_w1[arr_idx][w];
    end
  end

  always @(posedge CLK) begin
    if (upd_en) begin
      m_valid[arr_idx][upd_way] <= upd_valid;
      m_dirty[arr_idx][upd_way] <= upd_dirty;
    end
  end

  task set_line(input int s, input int w, input logic v, input logic d,
                input logic [TAGW-1:0] t, input logic [31:0] a, input logic [31:0] b);
    m_valid[s][w] <= v;
    m_dirty[s][w] <= d;
    m_tag[s][w]   <= t;
    m_w0[s][w]    <= a;
    m_w1[s][w]    <= b;
  endtask

  // Checking and scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } word_t;

  typedef struct packed {
    logic [0:0] way;
    logic       valid;
    logic       dirty;
  } upd_t;

  word_t word_q[$];
  upd_t  upd_q[$];
  word_t mon_w;
  upd_t  mon_u;

  // A word counts as accepted when dwait is low while the responder drives it.
  always @(negedge CLK) begin
    if (nRST) begin
      if (ccif.cctrans && !ccif.dwait && ccif.daddr != 32'h0) begin
        if (word_q.size() == 0) begin
          check("fwd_unexpected", {32'h0, ccif.daddr}, 64'h0);
        end else begin
          mon_w = word_q.pop_front();
          check("fwd_addr", {32'h0, ccif.daddr}, {32'h0, mon_w.addr});
          check("fwd_data", {32'h0, ccif.dstore}, {32'h0, mon_w.data});
        end
      end
      if (upd_en) begin
        if (upd_q.size() == 0) begin
          check("upd_unexpected", {61'h0, upd_way, upd_valid, upd_dirty}, 64'h0);
        end else begin
          mon_u = upd_q.pop_front();
          check("upd_fields", {61'h0, upd_way, upd_valid, upd_dirty}, {61'h0, mon_u});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (snoop_busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", {63'h0, snoop_busy}, 64'h0);
  endtask

  function automatic logic [31:0] mk_addr(input int tag, input int set);
    return 32'((tag << (3 + IDXW)) | (set << 3));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_out"}, {ccif.cctrans, snoop_busy, upd_en, upd_way, upd_valid, upd_dirty,
                          arr_idx}, '0);
    check({tag, "_bus"}, {ccif.daddr, ccif.dstore}, 64'h0);
  endtask

  logic [31:0] a;

  initial begin
    ccif.ccwait      = 1'b0;
    ccif.ccinv       = 1'b0;
    ccif.ccsnoopaddr = 32'h0;
    ccif.dwait       = 1'b1;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        set_line(s, w, 1'b0, 1'b0, '0, 32'h0, 32'h0);

    #2;
    check_all_zero("reset");
    tick();
    nRST = 1'b1;
    tick();

    // 1: M hit forward on set 1 way 1.
    set_line(1, 0, 1'b0, 1'b0, 26'd0, 32'h0, 32'h0);
    set_line(1, 1, 1'b1, 1'b1, 26'd1, 32'hDEADBEEF, 32'h12345678);
    tick();
    a = mk_addr(1, 1);
    ccif.ccsnoopaddr = a;
    ccif.ccwait = 1'b1;
    word_q.push_back('{addr: a, data: 32'hDEADBEEF});
    word_q.push_back('{addr: a | 32'h4, data: 32'h12345678});
    upd_q.push_back('{way: 1'b1, valid: 1'b1, dirty: 1'b0});
    #1;
    check("t1_idle_idx", {61'h0, arr_idx}, 64'd1);
    tick();                                   // LOOKUP
    ccif.ccsnoopaddr = 32'h0;
    #1;
    check("t1_lookup", {62'h0, ccif.cctrans, snoop_busy}, 64'b11);
    check("t1_idx_held", {61'h0, arr_idx}, 64'd1);
    tick();                                   // SUP0
    check("t1_sup0", {ccif.daddr, ccif.dstore}, {32'h48, 32'hDEADBEEF});
    ccif.dwait = 1'b0;
    tick();                                   // GAP
    ccif.dwait = 1'b1;
    check("t1_gap", {31'h0, ccif.cctrans, ccif.daddr}, {31'h0, 1'b1, 32'h48});
    tick();                                   // SUP1
    check("t1_sup1", {ccif.daddr, ccif.dstore}, {32'h4C, 32'h12345678});
    ccif.dwait = 1'b0;
    tick();                                   // DOWN: 5 cycles after ccwait rise
    ccif.dwait = 1'b1;
    ccif.ccwait = 1'b0;
    check("t1_down", {60'h0, upd_en, upd_way, upd_valid, upd_dirty}, {60'h0, 4'b1110});
    check("t1_down_bus", {31'h0, ccif.cctrans, ccif.daddr}, 64'h0);
    tick();
    check("t1_idle", {62'h0, snoop_busy, upd_en}, 64'h0);
    check("t1_line_s", {62'h0, m_valid[1][1], m_dirty[1][1]}, 64'b10);

    // 2: clean S hit, ccwait held three cycles.
    set_line(2, 0, 1'b1, 1'b0, 26'd5, 32'hAAAA0000, 32'hBBBB0000);
    tick();
    ccif.ccsnoopaddr = mk_addr(5, 2);
    ccif.ccwait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold", {ccif.dstore, 30'h0, ccif.cctrans, snoop_busy}, 64'h1);
    end
    ccif.ccwait = 1'b0;
    tick();
    check("t2_idle", {63'h0, snoop_busy}, 64'h0);
    check("t2_line", {62'h0, m_valid[2][0], m_dirty[2][0]}, 64'b10);

    // 3: miss snoop, then invalidate with both ways matching (way0 wins).
    tick();
    ccif.ccsnoopaddr = mk_addr(7, 3);
    ccif.ccwait = 1'b1;
    tick();
    check("t3_miss", {62'h0, ccif.cctrans, snoop_busy}, 64'b01);
    ccif.ccwait = 1'b0;
    wait_idle(4);
    set_line(4, 0, 1'b1, 1'b0, 26'd9, 32'h1, 32'h2);
    set_line(4, 1, 1'b1, 1'b0, 26'd9, 32'h3, 32'h4);
    tick();
    ccif.ccsnoopaddr = mk_addr(9, 4);
    ccif.ccinv = 1'b1;
    upd_q.push_back('{way: 1'b0, valid: 1'b0, dirty: 1'b0});
    tick();                                   // INVAL
    ccif.ccinv = 1'b0;
    check("t3_inval", {60'h0, snoop_busy, upd_en, upd_way, upd_valid}, {60'h0, 4'b1100});
    tick();
    check("t3_one_cycle", {62'h0, upd_en, snoop_busy}, 64'h0);
    check("t3_lines", {62'h0, m_valid[4][0], m_valid[4][1]}, 64'b01);

    // 4: abort in GAP.
    set_line(5, 0, 1'b1, 1'b1, 26'd2, 32'hCAFE0001, 32'hCAFE0002);
    tick();
    a = mk_addr(2, 5);
    ccif.ccsnoopaddr = a;
    ccif.ccwait = 1'b1;
    word_q.push_back('{addr: a, data: 32'hCAFE0001});
    tick();                                   // LOOKUP
    tick();                                   // SUP0
    ccif.dwait = 1'b0;
    tick();                                   // GAP
    ccif.dwait = 1'b1;
    ccif.ccwait = 1'b0;
    check("t4_gap", {63'h0, ccif.cctrans}, 64'h1);
    tick();
    check("t4_abort", {ccif.daddr, 30'h0, ccif.cctrans, snoop_busy}, 64'h0);
    tick();
    check("t4_dirty", {62'h0, m_valid[5][0], m_dirty[5][0]}, 64'b11);

    // 5: ccwait and ccinv together on an M line: snoop path wins.
    set_line(6, 1, 1'b1, 1'b1, 26'd3, 32'h55550000, 32'h55550004);
    tick();
    a = mk_addr(3, 6);
    ccif.ccsnoopaddr = a;
    ccif.ccwait = 1'b1;
    ccif.ccinv = 1'b1;
    word_q.push_back('{addr: a, data: 32'h55550000});
    word_q.push_back('{addr: a | 32'h4, data: 32'h55550004});
    upd_q.push_back('{way: 1'b1, valid: 1'b1, dirty: 1'b0});
    tick();                                   // LOOKUP
    ccif.ccinv = 1'b0;
    check("t5_lookup", {62'h0, ccif.cctrans, snoop_busy}, 64'b11);
    tick();                                   // SUP0
    ccif.dwait = 1'b0;
    tick();                                   // GAP
    ccif.dwait = 1'b1;
    tick();                                   // SUP1
    ccif.dwait = 1'b0;
    tick();                                   // DOWN
    ccif.dwait = 1'b1;
    ccif.ccwait = 1'b0;
    check("t5_down", {60'h0, upd_en, upd_way, upd_valid, upd_dirty}, {60'h0, 4'b1110});
    tick();
    tick();
    check("t5_no_inval", {62'h0, m_valid[6][1], m_dirty[6][1]}, 64'b10);

    // 6: reset asserted mid-supply.
    set_line(7, 0, 1'b1, 1'b1, 26'd4, 32'h77770000, 32'h77770004);
    tick();
    a = mk_addr(4, 7);
    ccif.ccsnoopaddr = a;
    ccif.ccwait = 1'b1;
    word_q.push_back('{addr: a, data: 32'h77770000});
    tick();                                   // LOOKUP
    tick();                                   // SUP0
    ccif.dwait = 1'b0;
    tick();                                   // GAP
    ccif.dwait = 1'b1;
    tick();                                   // SUP1
    check("t6_sup1", {ccif.daddr, ccif.dstore}, {a | 32'h4, 32'h77770004});
    #2;
    nRST = 1'b0;
    #1;
    check_all_zero("t6_async");
    ccif.ccwait = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();
    check("t6_after", {62'h0, snoop_busy, ccif.cctrans}, 64'h0);
    check("t6_line", {62'h0, m_valid[7][0], m_dirty[7][0]}, 64'b11);

    check("sb_words_left", 64'(word_q.size()), 64'h0);
    check("sb_upds_left", 64'(upd_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
